hash_match_table: RTL and testbench
===================================

Name: hash_match_table

Overview:
- Parametrised successor to the fixed 64-entry NT hash checker.
- Stores up to DEPTH target hashes of HASH_W bits and answers membership queries from the cracking pipeline.
- Compares LANES entries per cycle instead of all entries at once, so area can be traded against latency.
- Reports the index of the lowest matching entry. Supports table clear and an optional de-duplicating store mode.

Parameters:
- HASH_W, 128, hash width in bits.
- DEPTH, 64, table entries; must be a multiple of LANES and at least 1.
- LANES, 8, entries compared per scan cycle.
- DEDUP, 0, 1 = a store first scans the table and skips the write if the hash is already present.
- IDX_W, $clog2(DEPTH), index width (derived; minimum 1).

Ports:
- clk  in  1  clock
- nrst  in  1  reset, synchronous, active-low
- store_valid  in  1  request: append hash_in to the table
- check_valid  in  1  request: look up hash_in
- clear  in  1  request: empty the table
- hash_in  in  HASH_W  hash operand, sampled on the accept edge only
- busy  out  1  high while a request is in progress; new requests are ignored
- result_valid  out  1  one-cycle completion pulse for every accepted request
- match  out  1  hash found (check, or DEDUP store); valid while result_valid is high
- match_idx  out  IDX_W  lowest matching index; 0 when match=0
- store_err  out  1  store rejected because the table is full; valid while result_valid is high
- count  out  IDX_W+1  number of valid entries
- full  out  1  count==DEPTH

Behaviour:
- Reset (nrst=0 at a clk edge): count=0, busy=0, result_valid=0, match=0, match_idx=0, store_err=0, state=IDLE.
  - Entry storage need not be cleared; validity is defined solely by index<count.
  - Reset mid-operation aborts the request with no result_valid pulse.
- Accept: at an edge where busy=0 and any request is high. Priority is clear > store > check; lower-priority simultaneous requests are dropped.
  - hash_in is latched; busy=1 from the next cycle.
  - Requests while busy=1 are ignored, not queued.
- States: IDLE, SCAN, WRITE, CLEAR.
- CLEAR:
  - Edge A+1 (A = accept edge): count<=0, result_valid<=1, match=0, store_err=0, busy<=0.
- Store, DEDUP=0 (IDLE->WRITE):
  - Edge A+1, count<DEPTH: entry[count]<=latched hash, count<=count+1, store_err=0.
  - Edge A+1, full: no write, store_err=1.
  - Either case: match=0, result_valid<=1, busy<=0. Duplicates are stored.
- Check (IDLE->SCAN):
  - Group pointer g starts at 0. At each SCAN edge, compare entries g*LANES..g*LANES+LANES-1 that have index<count against the latched hash.
  - Hit, or g is the last group containing valid entries, or count=0: result_valid<=1, match, and match_idx = lowest hit index in that group; busy<=0; return to IDLE.
  - Otherwise g<=g+1.
  - Latency: accept edge to result edge = max(1, ceil(count/LANES)) cycles without a hit, or (hit group +1) cycles with a hit (early exit).
- Store, DEDUP=1: performs SCAN as for check.
  - Hit: result with match=1, match_idx=existing index, no write, store_err=0.
  - Miss: one extra WRITE cycle, then the DEDUP=0 store rules apply (match=0).
  - The hit check takes precedence over full: an existing hash in a full table returns match=1, store_err=0.
- Result fields are held until the next result_valid pulse. busy=0 during the result_valid cycle, so a new request may be accepted on the edge that ends it.
- count saturates at DEPTH and never wraps. full is derived from registered count.
- An entry at index>=count never matches, including stale data remaining after a clear.

Test Plan:
- DEPTH=64, LANES=8, DEDUP=0:
  - Store 3 hashes H0..H2, then check H2 -> result_valid 1 cycle after accept, match=1, match_idx=2, count=3.
- Same configuration:
  - Fill 64 entries, check an absent hash -> result exactly 8 cycles after accept, match=0.
  - Then a 65th store -> store_err=1, count stays 64, full=1.
- Stale data:
  - Store H0, clear, check H0 -> match=0, count=0, result 1 cycle after accept.
  - Then store H5, check H5 -> match=1, idx=0.
- Priority and busy:
  - Assert clear+store+check on the same edge with 5 entries -> only clear executes, count=0.
  - Pulse check_valid while busy -> ignored, exactly one result_valid.
- DEDUP=1, table holding H7 at idx 4 of 9 entries:
  - Store H7 -> match=1, match_idx=4, count stays 9.
  - Store new H8 -> match=0, count=10, H8 later found at idx 9.
- Reset mid-operation:
  - Drop nrst during the 4th SCAN cycle of a 64-entry check -> no result_valid; all outputs take reset values; count=0.

Source files
------------

// File: rtl/hash_match_table.sv
// Hash membership table: stores target hashes, answers lookups by
// scanning LANES entries per cycle and reporting the lowest hit.
module hash_match_table #(
  parameter int HASH_W = 128,
  parameter int DEPTH  = 64,
  parameter int LANES  = 8,
  parameter int DEDUP  = 0,
  parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              store_valid,
  input  logic              check_valid,
  input  logic              clear,
  input  logic [HASH_W-1:0] hash_in,
  output logic              busy,
  output logic              result_valid,
  output logic              match,
  output logic [IDX_W-1:0]  match_idx,
  output logic              store_err,
  output logic [IDX_W:0]    count,
  output logic              full
);

  localparam int NGRP  = DEPTH / LANES;
  localparam int GRP_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int CNT_W = IDX_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_WRITE,
    S_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [HASH_W-1:0]  hash_q, hash_d;
  logic [GRP_W-1:0]   grp_q, grp_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_store_q, is_store_d;
  logic               rv_q, rv_d;
  logic               match_q, match_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               err_q, err_d;
  logic [HASH_W-1:0]  mem_q [DEPTH];

  logic               wr_en;
  logic               full_c;
  logic               hit;
  logic               last;
  logic [IDX_W-1:0]   hit_idx;
  int                 base;

  assign full_c = (cnt_q == CNT_W'(DEPTH));

  // Lanes are walked high to low so the lowest hit wins.
  always_comb begin
    base    = int'(grp_q) * LANES;
    hit     = 1'b0;
    hit_idx = '0;
    for (int l = LANES - 1; l >= 0; l--) begin
      if ((base + l) < int'(cnt_q) &&
          mem_q[IDX_W'(base + l)] == hash_q) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(base + l);
      end
    end
    last = (base + LANES) >= int'(cnt_q);
  end

  always_comb begin
    state_d    = state_q;
    hash_d     = hash_q;
    grp_d      = grp_q;
    cnt_d      = cnt_q;
    is_store_d = is_store_q;
    rv_d       = 1'b0;
    match_d    = match_q;
    idx_d      = idx_q;
    err_d      = err_q;
    wr_en      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (clear) begin
          hash_d  = hash_in;
          state_d = S_CLEAR;
        end else if (store_valid) begin
          hash_d     = hash_in;
          grp_d      = '0;
          is_store_d = 1'b1;
          state_d    = (DEDUP != 0) ? S_SCAN : S_WRITE;
        end else if (check_valid) begin
          hash_d     = hash_in;
          grp_d      = '0;
          is_store_d = 1'b0;
          state_d    = S_SCAN;
        end
      end
      S_CLEAR: begin
        cnt_d   = '0;
        rv_d    = 1'b1;
        match_d = 1'b0;
        idx_d   = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      S_WRITE: begin
        rv_d    = 1'b1;
        match_d = 1'b0;
        idx_d   = '0;
        if (full_c) begin
          err_d = 1'b1;
        end else begin
          wr_en = 1'b1;
          cnt_d = cnt_q + 1'b1;
          err_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      S_SCAN: begin
        if (hit || last) begin
          if (is_store_q && !hit) begin
            state_d = S_WRITE;
          end else begin
            rv_d    = 1'b1;
            match_d = hit;
            idx_d   = hit ? hit_idx : '0;
            err_d   = 1'b0;
            state_d = S_IDLE;
          end
        end else begin
          grp_d = grp_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      grp_q      <= '0;
      cnt_q      <= '0;
      is_store_q <= 1'b0;
      rv_q       <= 1'b0;
      match_q    <= 1'b0;
      idx_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      grp_q      <= grp_d;
      cnt_q      <= cnt_d;
      is_store_q <= is_store_d;
      rv_q       <= rv_d;
      match_q    <= match_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
    end
  end

  // Entry storage is not reset; only index<count is ever considered valid.
  always_ff @(posedge clk) begin
    hash_q <= hash_d;
    if (wr_en) begin
      mem_q[cnt_q[IDX_W-1:0]] <= hash_q;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign result_valid = rv_q;
  assign match        = match_q;
  assign match_idx    = idx_q;
  assign store_err    = err_q;
  assign count        = cnt_q;
  assign full         = full_c;

endmodule

// File: tb/tb_hash_match_table.sv
// Randomised and directed bench for hash_match_table, one plain
// instance and one de-duplicating instance.
module tb_hash_match_table;

  logic clk;
  logic nrst;
  logic st [2];
  logic ck [2];
  logic cl [2];
  logic [127:0] hi [2];
  logic bsy [2];
  logic rv [2];
  logic mt [2];
  logic [5:0] mix [2];
  logic se [2];
  logic [6:0] cnt [2];
  logic fu [2];

  int n_tests;
  int n_fail;

  logic [127:0] mtab [2][64];
  int mcnt [2];

  hash_match_table #(.HASH_W(128), .DEPTH(64), .LANES(8), .DEDUP(0)) u0 (
    .clk(clk), .nrst(nrst),
    .store_valid(st[0]), .check_valid(ck[0]), .clear(cl[0]),
    .hash_in(hi[0]), .busy(bsy[0]), .result_valid(rv[0]),
    .match(mt[0]), .match_idx(mix[0]), .store_err(se[0]),
    .count(cnt[0]), .full(fu[0])
  );

  hash_match_table #(.HASH_W(128), .DEPTH(64), .LANES(8), .DEDUP(1)) u1 (
    .clk(clk), .nrst(nrst),
    .store_valid(st[1]), .check_valid(ck[1]), .clear(cl[1]),
    .hash_in(hi[1]), .busy(bsy[1]), .result_valid(rv[1]),
    .match(mt[1]), .match_idx(mix[1]), .store_err(se[1]),
    .count(cnt[1]), .full(fu[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] rnd_hash();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic int lookup(int d, logic [127:0] h);
    for (int i = 0; i < mcnt[d]; i++)
      if (mtab[d][i] == h) return i;
    return -1;
  endfunction

  function automatic int scan_lat(int d);
    return (mcnt[d] == 0) ? 1 : (mcnt[d] + 7) / 8;
  endfunction

  // kind: 0 store, 1 check, 2 clear, 3 all three at once
  task automatic predict(input int d, input int kind, input logic [127:0] h,
                         output bit em, output int eidx,
                         output bit eerr, output int elat);
    int mi;
    mi = lookup(d, h);
    em = 0; eidx = 0; eerr = 0; elat = 1;
    if (kind >= 2) begin
      mcnt[d] = 0;
    end else if (kind == 1) begin
      em = (mi >= 0);
      eidx = em ? mi : 0;
      elat = em ? mi / 8 + 1 : scan_lat(d);
    end else if (d == 1 && mi >= 0) begin
      em = 1; eidx = mi; elat = mi / 8 + 1;
    end else begin
      elat = (d == 1) ? scan_lat(d) + 1 : 1;
      if (mcnt[d] < 64) begin
        mtab[d][mcnt[d]] = h;
        mcnt[d]++;
      end else begin
        eerr = 1;
      end
    end
  endtask

  task automatic req(input int d, input int kind, input logic [127:0] h,
                     output int lat);
    @(negedge clk);
    hi[d] = h;
    st[d] = (kind == 0 || kind == 3);
    ck[d] = (kind == 1 || kind == 3);
    cl[d] = (kind == 2 || kind == 3);
    @(posedge clk); #1;
    st[d] = 0; ck[d] = 0; cl[d] = 0;
    lat = 0;
    while (!rv[d] && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op(input int d, input int kind, input logic [127:0] h,
                    output bit em, output int eidx, output bit eerr,
                    output int elat, output int lat);
    predict(d, kind, h, em, eidx, eerr, elat);
    req(d, kind, h, lat);
  endtask

  task automatic test_reset();
    nrst = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if (cnt[d] !== 7'd0 || bsy[d] !== 1'b0 || rv[d] !== 1'b0 ||
          mt[d] !== 1'b0 || mix[d] !== 6'd0 || se[d] !== 1'b0 ||
          fu[d] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: cnt=%0d busy=%b rv=%b m=%b idx=%0d err=%b full=%b, want all 0",
                 d, cnt[d], bsy[d], rv[d], mt[d], mix[d], se[d], fu[d]);
      end
      mcnt[d] = 0;
    end
    @(negedge clk);
    nrst = 1;
  endtask

  task automatic test_store_check();
    logic [127:0] h [3];
    bit em, ee; int ei, el, lat;
    for (int i = 0; i < 3; i++) begin
      h[i] = rnd_hash();
      op(0, 0, h[i], em, ei, ee, el, lat);
    end
    op(0, 1, h[2], em, ei, ee, el, lat);
    n_tests++;
    if (lat !== 1 || mt[0] !== 1'b1 || mix[0] !== 6'd2 || cnt[0] !== 7'd3) begin
      n_fail++;
      $display("FAIL store_check: lat=%0d m=%b idx=%0d cnt=%0d, want 1 1 2 3",
               lat, mt[0], mix[0], cnt[0]);
    end
  endtask

  task automatic test_stale();
    logic [127:0] h0, h5;
    bit em, ee; int ei, el, lat;
    h0 = rnd_hash();
    h5 = rnd_hash();
    op(0, 2, 0, em, ei, ee, el, lat);
    op(0, 0, h0, em, ei, ee, el, lat);
    op(0, 2, 0, em, ei, ee, el, lat);
    op(0, 1, h0, em, ei, ee, el, lat);
    n_tests++;
    if (lat !== 1 || mt[0] !== 1'b0 || cnt[0] !== 7'd0) begin
      n_fail++;
      $display("FAIL stale_check: lat=%0d m=%b cnt=%0d, want 1 0 0",
               lat, mt[0], cnt[0]);
    end
    op(0, 0, h5, em, ei, ee, el, lat);
    op(0, 1, h5, em, ei, ee, el, lat);
    n_tests++;
    if (mt[0] !== 1'b1 || mix[0] !== 6'd0 || cnt[0] !== 7'd1) begin
      n_fail++;
      $display("FAIL stale_restore: m=%b idx=%0d cnt=%0d, want 1 0 1",
               mt[0], mix[0], cnt[0]);
    end
  endtask

  task automatic test_priority();
    bit em, ee; int ei, el, lat;
    op(0, 2, 0, em, ei, ee, el, lat);
    for (int i = 0; i < 5; i++) op(0, 0, rnd_hash(), em, ei, ee, el, lat);
    op(0, 3, rnd_hash(), em, ei, ee, el, lat);
    n_tests++;
    if (lat !== 1 || cnt[0] !== 7'd0 || mt[0] !== 1'b0 || se[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL priority: lat=%0d cnt=%0d m=%b err=%b, want 1 0 0 0",
               lat, cnt[0], mt[0], se[0]);
    end
  endtask

  task automatic test_random(input int d, input int n);
    logic [127:0] h;
    bit em, ee; int ei, el, lat, kind, r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 19);
      kind = (r < 9) ? 0 : (r < 19) ? 1 : 2;
      if (mcnt[d] > 0 && $urandom_range(0, 1) == 1)
        h = mtab[d][$urandom_range(0, mcnt[d] - 1)];
      else
        h = rnd_hash();
      op(d, kind, h, em, ei, ee, el, lat);
      n_tests++;
      if (lat !== el || mt[d] !== em || int'(mix[d]) !== ei ||
          int'(cnt[d]) !== mcnt[d] || (kind != 1 && se[d] !== ee)) begin
        n_fail++;
        $display("FAIL random[%0d] op%0d k%0d: lat=%0d m=%b idx=%0d err=%b cnt=%0d, want %0d %b %0d %b %0d",
                 d, i, kind, lat, mt[d], mix[d], se[d], cnt[d],
                 el, em, ei, ee, mcnt[d]);
      end
    end
  endtask

  task automatic test_full();
    bit em, ee; int ei, el, lat, pulses;
    logic [127:0] absent;
    op(0, 2, 0, em, ei, ee, el, lat);
    for (int i = 0; i < 64; i++) op(0, 0, rnd_hash(), em, ei, ee, el, lat);
    n_tests++;
    if (cnt[0] !== 7'd64 || fu[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL fill: cnt=%0d full=%b, want 64 1", cnt[0], fu[0]);
    end
    absent = rnd_hash();
    op(0, 1, absent, em, ei, ee, el, lat);
    n_tests++;
    if (lat !== 8 || mt[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL full_miss: lat=%0d m=%b, want 8 0", lat, mt[0]);
    end
    op(0, 1, mtab[0][63], em, ei, ee, el, lat);
    n_tests++;
    if (lat !== 8 || mt[0] !== 1'b1 || mix[0] !== 6'd63) begin
      n_fail++;
      $display("FAIL last_hit: lat=%0d m=%b idx=%0d, want 8 1 63",
               lat, mt[0], mix[0]);
    end
    @(negedge clk);
    hi[0] = absent; ck[0] = 1;
    @(posedge clk); #1;
    ck[0] = 0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      if (c == 2) ck[0] = 1;
      if (c == 3) ck[0] = 0;
      @(posedge clk); #1;
      if (rv[0]) pulses++;
    end
    n_tests++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore: pulses=%0d, want 1", pulses);
    end
    op(0, 0, rnd_hash(), em, ei, ee, el, lat);
    n_tests++;
    if (se[0] !== 1'b1 || cnt[0] !== 7'd64 || fu[0] !== 1'b1 || lat !== 1) begin
      n_fail++;
      $display("FAIL overflow: err=%b cnt=%0d full=%b lat=%0d, want 1 64 1 1",
               se[0], cnt[0], fu[0], lat);
    end
  endtask

  task automatic test_dedup();
    logic [127:0] h7, h8;
    bit em, ee; int ei, el, lat;
    h7 = rnd_hash();
    h8 = rnd_hash();
    op(1, 2, 0, em, ei, ee, el, lat);
    for (int i = 0; i < 9; i++)
      op(1, 0, (i == 4) ? h7 : rnd_hash(), em, ei, ee, el, lat);
    op(1, 0, h7, em, ei, ee, el, lat);
    n_tests++;
    if (mt[1] !== 1'b1 || mix[1] !== 6'd4 || cnt[1] !== 7'd9 ||
        se[1] !== 1'b0 || lat !== 1) begin
      n_fail++;
      $display("FAIL dedup_hit: m=%b idx=%0d cnt=%0d err=%b lat=%0d, want 1 4 9 0 1",
               mt[1], mix[1], cnt[1], se[1], lat);
    end
    op(1, 0, h8, em, ei, ee, el, lat);
    n_tests++;
    if (mt[1] !== 1'b0 || cnt[1] !== 7'd10 || lat !== 3) begin
      n_fail++;
      $display("FAIL dedup_new: m=%b cnt=%0d lat=%0d, want 0 10 3",
               mt[1], cnt[1], lat);
    end
    op(1, 1, h8, em, ei, ee, el, lat);
    n_tests++;
    if (mt[1] !== 1'b1 || mix[1] !== 6'd9 || lat !== 2) begin
      n_fail++;
      $display("FAIL dedup_find: m=%b idx=%0d lat=%0d, want 1 9 2",
               mt[1], mix[1], lat);
    end
    for (int i = 10; i < 64; i++) op(1, 0, rnd_hash(), em, ei, ee, el, lat);
    op(1, 0, h8, em, ei, ee, el, lat);
    n_tests++;
    if (mt[1] !== 1'b1 || se[1] !== 1'b0 || mix[1] !== 6'd9 || cnt[1] !== 7'd64) begin
      n_fail++;
      $display("FAIL dedup_full_hit: m=%b err=%b idx=%0d cnt=%0d, want 1 0 9 64",
               mt[1], se[1], mix[1], cnt[1]);
    end
    op(1, 0, rnd_hash(), em, ei, ee, el, lat);
    n_tests++;
    if (mt[1] !== 1'b0 || se[1] !== 1'b1 || lat !== 9) begin
      n_fail++;
      $display("FAIL dedup_full_miss: m=%b err=%b lat=%0d, want 0 1 9",
               mt[1], se[1], lat);
    end
    op(1, 2, 0, em, ei, ee, el, lat);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    hi[0] = rnd_hash(); ck[0] = 1;
    @(posedge clk); #1;
    ck[0] = 0;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (rv[0]) seen = 1;
    end
    nrst = 0;
    @(posedge clk); #1;
    if (rv[0]) seen = 1;
    n_tests++;
    if (seen || rv[0] !== 1'b0 || cnt[0] !== 7'd0 || bsy[0] !== 1'b0 ||
        mt[0] !== 1'b0 || mix[0] !== 6'd0 || se[0] !== 1'b0 || fu[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: seen=%b rv=%b cnt=%0d busy=%b m=%b idx=%0d err=%b full=%b, want all 0",
               seen, rv[0], cnt[0], bsy[0], mt[0], mix[0], se[0], fu[0]);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (rv[0]) seen = 1;
    end
    n_tests++;
    if (seen || bsy[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet: seen=%b busy=%b, want 0 0", seen, bsy[0]);
    end
    mcnt[0] = 0;
    mcnt[1] = 0;
    @(negedge clk);
    nrst = 1;
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      st[d] = 0; ck[d] = 0; cl[d] = 0; hi[d] = '0; mcnt[d] = 0;
    end
    test_reset();
    test_store_check();
    test_stale();
    test_priority();
    test_random(0, 60);
    test_full();
    test_dedup();
    test_random(1, 60);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
